// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared types and helpers for the capture/display block: display
//            FSM states, the blank segment pattern and the hex-to-7-segment
//            encoder (active-low, bit0=a .. bit6=g, bit7=dp).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment pattern for one hex nibble; decimal point always off.
  function automatic logic [7:0] hex7(input logic [3:0] i_nib);
    logic [7:0] w_seg;
    case (i_nib)
      4'h0:    w_seg = 8'hC0;
      4'h1:    w_seg = 8'hF9;
      4'h2:    w_seg = 8'hA4;
      4'h3:    w_seg = 8'hB0;
      4'h4:    w_seg = 8'h99;
      4'h5:    w_seg = 8'h92;
      4'h6:    w_seg = 8'h82;
      4'h7:    w_seg = 8'hF8;
      4'h8:    w_seg = 8'h80;
      4'h9:    w_seg = 8'h90;
      4'hA:    w_seg = 8'h88;
      4'hB:    w_seg = 8'h83;
      4'hC:    w_seg = 8'hC6;
      4'hD:    w_seg = 8'hA1;
      4'hE:    w_seg = 8'h86;
      default: w_seg = 8'h8E;
    endcase
    return w_seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_capture_display_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchronizer, persistence-count debouncer and rising
//            edge detector for a raw, bouncy push button. press is a single
//            cycle pulse on each accepted press (never on release).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_db,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_db_q;
  logic [CW-1:0] r_cnt;

  // Synchronize, then accept a new level only after it persists long enough;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= btn;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btn_db = r_db;
  assign press  = r_db & ~r_db_q;

endmodule

`default_nettype wire

// File: rtl/seg_capture_display.sv
// ============================================================================
// Module   : seg_capture_display
// Brief    : Latches the free-running random byte on each debounced button
//            press and shows it as two active-low hex digits. Counts captures.
//            Optional build macro SEG_ZERO_BLANK_EN blanks a zero high digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_capture_display
  import seg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rand_data,
  input  logic       btn,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] hold_val,
  output logic       valid,
  output logic [7:0] cap_cnt
);

  logic       w_btn_db;
  logic       w_press;
  logic       w_cap;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] w_seg0_nxt;
  logic [7:0] w_seg1_nxt;
  logic [7:0] r_hold;
  logic [7:0] r_cnt;
  logic       r_valid;
  logic [7:0] r_seg0;
  logic [7:0] r_seg1;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .btn_db(w_btn_db),
    .press (w_press)
  );

  // press already implies the accepted level is high; the AND is a no-op guard.
  assign w_cap = w_press & w_btn_db;

  // Display state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next segment patterns derived from the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_seg0_nxt  = SEG_BLANK;
    w_seg1_nxt  = SEG_BLANK;
    case (r_state)
      BLANK: begin
        if (w_cap) w_state_nxt = SHOW;
      end
      SHOW: begin
        w_seg0_nxt = hex7(r_hold[3:0]);
`ifdef SEG_ZERO_BLANK_EN
        if (r_hold[7:4] != 4'h0) w_seg1_nxt = hex7(r_hold[7:4]);
`else
        w_seg1_nxt = hex7(r_hold[7:4]);
`endif
      end
      default: w_state_nxt = BLANK;
    endcase
  end

  // Capture the random byte and count presses on each capture pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold  <= 8'h00;
      r_cnt   <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_cap) begin
      r_hold  <= rand_data;
      r_cnt   <= r_cnt + 8'd1;
      r_valid <= 1'b1;
    end
  end

  // Registered segment drivers, one cycle behind the captured value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg0 <= SEG_BLANK;
      r_seg1 <= SEG_BLANK;
    end else begin
      r_seg0 <= w_seg0_nxt;
      r_seg1 <= w_seg1_nxt;
    end
  end

  assign seg0     = r_seg0;
  assign seg1     = r_seg1;
  assign hold_val = r_hold;
  assign valid    = r_valid;
  assign cap_cnt  = r_cnt;

endmodule

`default_nettype wire
